// File: rtl/mode_osd.sv
// Mode-indicator on-screen display: overlays 8 cells after each mode change, opaque then half-blended, then removed.
// Latency: fixed 2 cycles on hs/vs/de/data; no stalls, no backpressure.
module mode_osd #(
    parameter int unsigned H_WIDTH     = 1920,
    parameter int unsigned V_HEIGHT    = 1080,
    parameter int unsigned OSD_X       = 32,
    parameter int unsigned OSD_Y       = 32,
    parameter int unsigned CELL_LOG2   = 4,
    parameter int unsigned SHOW_FRAMES = 120,
    parameter int unsigned FADE_FRAMES = 30
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  mode_i,
    input  logic        vin_hs_i,
    input  logic        vin_vs_i,
    input  logic        vin_de_i,
    input  logic [23:0] vin_data_i,
    output logic        vout_hs_o,
    output logic        vout_vs_o,
    output logic        vout_de_o,
    output logic [23:0] vout_data_o
);

    localparam int unsigned XW   = $clog2(H_WIDTH + 1);
    localparam int unsigned YW   = $clog2(V_HEIGHT + 1);
    localparam int unsigned CMAX = (SHOW_FRAMES > FADE_FRAMES) ? SHOW_FRAMES : FADE_FRAMES;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int unsigned CELL = 1 << CELL_LOG2;

    typedef enum logic [1:0] {IDLE, SHOW, FADE} state_e;

    // stage 1
    logic          hs1_q, vs1_q, de1_q;
    logic [23:0]   data1_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_shown_q, mode_shown_d;

    // stage 2
    logic          vout_hs_q, vout_vs_q, vout_de_q;
    logic [23:0]   vout_data_q, vout_data_d;

    logic vs_rise, de_rise, de_fall;

    assign vs_rise = vin_vs_i & ~vs1_q;
    assign de_rise = vin_de_i & ~de1_q;
    assign de_fall = ~vin_de_i & de1_q;

    // Counters are tagged onto the pixel as it enters stage 1.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vin_de_i) begin
            if (de_rise)
                x_d = '0;
            else if (x_q != '1)
                x_d = x_q + XW'(1);
        end
        if (vs_rise)
            y_d = '0;
        else if (de_fall && y_q != '1)
            y_d = y_q + YW'(1);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_shown_d = mode_shown_q;
        if (vs_rise) begin
            if (mode_i != mode_shown_q) begin
                mode_shown_d = mode_i;
                state_d      = SHOW;
                cnt_d        = CW'(SHOW_FRAMES - 1);
            end else begin
                case (state_q)
                    SHOW: begin
                        if (cnt_q == '0) begin
                            state_d = FADE;
                            cnt_d   = CW'(FADE_FRAMES - 1);
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    FADE: begin
                        if (cnt_q == '0)
                            state_d = IDLE;
                        else
                            cnt_d = cnt_q - CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [31:0] x32, y32, x_off, cell_idx;
    logic        in_cell;
    logic [23:0] osd_col, blend_col;

    // Cell index by shift; the saturated x value is never below H_WIDTH.
    always_comb begin
        x32      = 32'(x_q);
        y32      = 32'(y_q);
        x_off    = x32 - OSD_X;
        cell_idx = x_off >> CELL_LOG2;
        in_cell  = de1_q
                && (x32 >= OSD_X) && (x32 < H_WIDTH) && (cell_idx < 32'd8)
                && (y32 >= OSD_Y) && (y32 < OSD_Y + CELL) && (y32 < V_HEIGHT);
        osd_col  = (cell_idx[2:0] == mode_shown_q) ? 24'hFFFFFF : 24'h404040;
        blend_col[23:16] = {1'b0, data1_q[23:17]} + {1'b0, osd_col[23:17]};
        blend_col[15:8]  = {1'b0, data1_q[15:9]}  + {1'b0, osd_col[15:9]};
        blend_col[7:0]   = {1'b0, data1_q[7:1]}   + {1'b0, osd_col[7:1]};
        vout_data_d = data1_q;
        if (in_cell) begin
            if (state_q == SHOW)
                vout_data_d = osd_col;
            else if (state_q == FADE)
                vout_data_d = blend_col;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            de1_q        <= 1'b0;
            data1_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            mode_shown_q <= '0;
            vout_hs_q    <= 1'b0;
            vout_vs_q    <= 1'b0;
            vout_de_q    <= 1'b0;
            vout_data_q  <= '0;
        end else begin
            hs1_q        <= vin_hs_i;
            vs1_q        <= vin_vs_i;
            de1_q        <= vin_de_i;
            data1_q      <= vin_data_i;
            x_q          <= x_d;
            y_q          <= y_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_shown_q <= mode_shown_d;
            vout_hs_q    <= hs1_q;
            vout_vs_q    <= vs1_q;
            vout_de_q    <= de1_q;
            vout_data_q  <= vout_data_d;
        end
    end

    assign vout_hs_o   = vout_hs_q;
    assign vout_vs_o   = vout_vs_q;
    assign vout_de_o   = vout_de_q;
    assign vout_data_o = vout_data_q;

endmodule

// File: tb/tb_mode_osd.sv
// Directed bench for mode_osd on an 8x6 active frame with 2x2 cells at the origin.
module tb_mode_osd;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [2:0]  mode_i;
    logic        vin_hs_i, vin_vs_i, vin_de_i;
    logic [23:0] vin_data_i;
    logic        vout_hs_o, vout_vs_o, vout_de_o;
    logic [23:0] vout_data_o;

    always #5 clk = ~clk;

    mode_osd #(
        .H_WIDTH(8), .V_HEIGHT(6), .OSD_X(0), .OSD_Y(0), .CELL_LOG2(1),
        .SHOW_FRAMES(2), .FADE_FRAMES(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i),
        .vin_hs_i(vin_hs_i), .vin_vs_i(vin_vs_i), .vin_de_i(vin_de_i), .vin_data_i(vin_data_i),
        .vout_hs_o(vout_hs_o), .vout_vs_o(vout_vs_o), .vout_de_o(vout_de_o), .vout_data_o(vout_data_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [26:0] e1, e2;       // expected {hs,vs,de,data} in stage 1 and at the output
    string       cur_tag;
    int          ph;           // 0 passthrough, 1 opaque, 2 blended (input 0x808080)
    int          shown;
    int          ca_line, cb_line, rst_line;
    logic [2:0]  ca_mode, cb_mode;
    logic [23:0] base;

    task automatic cyc(input logic hs, input logic vs, input logic de,
                       input logic [23:0] d, input logic [23:0] ed);
        logic [26:0] got;
        vin_hs_i   = hs;
        vin_vs_i   = vs;
        vin_de_i   = de;
        vin_data_i = d;
        @(posedge clk);
        #1;
        if (rst_i) begin
            e1 = '0;
            e2 = '0;
        end else begin
            e2 = e1;
            e1 = {hs, vs, de, ed};
        end
        got = {vout_hs_o, vout_vs_o, vout_de_o, vout_data_o};
        checks++;
        assert (got === e2) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", cur_tag, got, e2);
        end
    endtask

    task automatic frame(input string tag);
        logic [23:0] d, ed;
        logic        white;
        cur_tag = tag;
        cyc(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
        cyc(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (y == ca_line && x == 0) mode_i = ca_mode;
                if (y == cb_line && x == 0) mode_i = cb_mode;
                if (y == rst_line && x == 3) rst_i = 1'b1;
                d  = (base == 24'h0) ? {8'(x * 16), 8'(y * 16), 8'hA5} : base;
                ed = d;
                if (ph != 0 && y < 2) begin
                    white = ((x / 2) == shown);
                    if (ph == 1) ed = white ? 24'hFFFFFF : 24'h404040;
                    else         ed = white ? 24'hBFBFBF : 24'h606060;
                end
                cyc(1'b0, 1'b0, 1'b1, d, ed);
                if (rst_i) begin
                    rst_i = 1'b0;
                    ph    = 0;
                end
            end
            cyc(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
            cyc(1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
            cyc(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
            cyc(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        end
        ca_line  = -1;
        cb_line  = -1;
        rst_line = -1;
    endtask

    initial begin
        rst_i    = 1'b1;
        mode_i   = 3'd0;
        e1       = '0;
        e2       = '0;
        ph       = 0;
        shown    = 0;
        base     = 24'h0;
        ca_line  = -1;
        cb_line  = -1;
        rst_line = -1;
        ca_mode  = 3'd0;
        cb_mode  = 3'd0;

        cur_tag = "reset_outputs";
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 24'h123456, 24'h123456);
        rst_i = 1'b0;
        cur_tag = "post_reset";
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);

        // passthrough; mode 0->3 mid-frame must not affect this frame
        ca_line = 2; ca_mode = 3'd3;
        frame("pass_then_change");

        base = 24'h808080;
        ph = 1; shown = 3;
        frame("show3_a");
        frame("show3_b");

        // change to 5 during FADE restarts SHOW next frame (cell 5 is off-screen)
        ph = 2;
        ca_line = 3; ca_mode = 3'd5;
        frame("fade3");

        ph = 1; shown = 5;
        frame("restart5");

        // 5->4->5 within one frame is invisible at the next vs rise
        ca_line = 1; ca_mode = 3'd4;
        cb_line = 4; cb_mode = 3'd5;
        frame("show5_toggle");

        ph = 2;
        frame("fade5_no_restart");

        ph = 0;
        ca_line = 2; ca_mode = 3'd0;
        frame("idle_after_fade");

        // reset mid-SHOW drops to IDLE; mode_i already equals mode_shown afterwards
        ph = 1; shown = 0;
        rst_line = 1;
        frame("show0_reset");

        ph = 0;
        frame("idle_after_reset");

        cur_tag = "tail";
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
